// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the funct3 load/store encodings, writeback-select codes, memory
// exception cause codes, the stage FSM state type and the access-legality
// decode that both the stage and its alignment helper agree on.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  localparam logic [1:0] MEM_EXC_NONE           = 2'b00;
  localparam logic [1:0] MEM_EXC_LOAD_MISALIGN  = 2'b01;
  localparam logic [1:0] MEM_EXC_STORE_MISALIGN = 2'b10;
  localparam logic [1:0] MEM_EXC_ILLEGAL        = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Cause code for a memory op; MEM_EXC_NONE for non-memory or legal ops.
  // Illegal encodings take priority over misalignment.
  function automatic logic [1:0] mem_exc_decode(input logic       ren,
                                                input logic       wen,
                                                input logic [2:0] f3,
                                                input logic [1:0] addr_lo);
    logic illegal;
    logic misal;
    illegal = (ren & wen)
            | ((ren | wen) & ((f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111)))
            | (wen & ((f3 == F3_BU) | (f3 == F3_HU)));
    misal   = (((f3 == F3_H) | (f3 == F3_HU)) & addr_lo[0])
            | ((f3 == F3_W) & (addr_lo != 2'b00));
    if (!(ren | wen))
      return MEM_EXC_NONE;
    if (illegal)
      return MEM_EXC_ILLEGAL;
    if (misal)
      return wen ? MEM_EXC_STORE_MISALIGN : MEM_EXC_LOAD_MISALIGN;
    return MEM_EXC_NONE;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus, single outstanding transaction.
//   dmem_req   : request, held until dmem_ack
//   dmem_we    : 1 store, 0 load
//   dmem_addr  : word-aligned address
//   dmem_wdata : lane-replicated store data
//   dmem_be    : byte enables (zero for loads)
//   dmem_ack   : transaction complete, dmem_rdata valid in the same cycle
//   dmem_rdata : read word
// master = memory stage, slave = memory / bus fabric.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational load/store lane alignment.
//   funct3, addr_lo : access size/sign and byte offset within the word
//   store_data      : rs2 value; wdata/be are the replicated bus data and
//                     byte enables for a store of that size at that offset
//   rdata           : bus read word; load_data is the addressed byte/half/
//                     word shifted to bit 0 and sign/zero-extended
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between execute and writeback.
//   clk, rst_n     : clock, synchronous active-low reset
//   ex_*           : instruction from execute (valid/ready handshake)
//   alu_out        : effective address or ALU result
//   store_data     : rs2 for stores
//   mem_ren/wen    : load / store
//   funct3         : access size/sign
//   wb_sel         : 0 ALU, 1 load data, 2 pc_plus4, 3 treated as ALU
//   reg_wen, rd    : destination write enable / index
//   pc_plus4       : link value
//   dmem           : data-memory bus (master side)
//   wb_*           : one-cycle registered writeback beat
//   mem_exc(_cause): exception pulse coincident with wb_valid
module mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   store_data,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        funct3,
  input  logic [1:0]        wb_sel,
  input  logic              reg_wen,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   pc_plus4,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              mem_exc,
  output logic [1:0]        mem_exc_cause
);

  mem_state_e        state;
  logic [XLEN-1:0]   addr_r;
  logic [2:0]        f3_r;
  logic [1:0]        wb_sel_r;
  logic              wen_r;
  logic [REG_AW-1:0] rd_r;
  logic [XLEN-1:0]   pc4_r;
  logic [1:0]        cause_r;
  logic [XLEN-1:0]   load_r;

  logic [1:0]        in_cause;
  logic              in_is_mem;
  logic [2:0]        al_f3;
  logic [1:0]        al_lo;
  logic [XLEN-1:0]   al_wdata;
  logic [3:0]        al_be;
  logic [XLEN-1:0]   al_load;
  logic [XLEN-1:0]   ld_src;
  logic [XLEN-1:0]   wb_mux;

  assign ex_ready  = (state == ST_IDLE);
  assign in_is_mem = mem_ren | mem_wen;
  assign in_cause  = mem_exc_decode(mem_ren, mem_wen, funct3, alu_out[1:0]);

  // One aligner serves both directions: store lanes are formed from the live
  // inputs at accept time, load extraction uses the captured access at ack.
  assign al_f3 = (state == ST_IDLE) ? funct3        : f3_r;
  assign al_lo = (state == ST_IDLE) ? alu_out[1:0]  : addr_r[1:0];

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .store_data (store_data),
    .rdata      (dmem.dmem_rdata),
    .wdata      (al_wdata),
    .be         (al_be),
    .load_data  (al_load)
  );

  always_comb begin
    ld_src = (state == ST_BUS) ? al_load : load_r;
    case (wb_sel_r)
      WB_SEL_MEM: wb_mux = ld_src;
      WB_SEL_PC:  wb_mux = pc4_r;
      default:    wb_mux = addr_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      addr_r          <= '0;
      f3_r            <= '0;
      wb_sel_r        <= '0;
      wen_r           <= 1'b0;
      rd_r            <= '0;
      pc4_r           <= '0;
      cause_r         <= MEM_EXC_NONE;
      load_r          <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      wb_valid        <= 1'b0;
      wb_wen          <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      mem_exc         <= 1'b0;
      mem_exc_cause   <= MEM_EXC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            addr_r   <= alu_out;
            f3_r     <= funct3;
            wb_sel_r <= wb_sel;
            rd_r     <= rd;
            pc4_r    <= pc_plus4;
            cause_r  <= in_cause;
            load_r   <= '0;
            wen_r    <= reg_wen & ~mem_wen & (in_cause == MEM_EXC_NONE);
            if (in_is_mem && (in_cause == MEM_EXC_NONE)) begin
              state           <= ST_BUS;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= mem_wen;
              dmem.dmem_addr  <= {alu_out[XLEN-1:2], 2'b00};
              dmem.dmem_wdata <= mem_wen ? al_wdata : '0;
              dmem.dmem_be    <= mem_wen ? al_be : 4'b0000;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_BUS: begin
          if (dmem.dmem_ack) begin
            load_r          <= al_load;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= '0;
            wb_valid        <= 1'b1;
            wb_wen          <= wen_r;
            wb_rd           <= rd_r;
            wb_data         <= wb_mux;
            mem_exc         <= 1'b0;
            mem_exc_cause   <= MEM_EXC_NONE;
            state           <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Entered from IDLE the beat is not yet registered: DONE spends one
          // cycle raising it, so non-memory ops see the same two-cycle
          // latency as a zero-wait memory op. Entered from BUS the beat is
          // already up and DONE just retires it.
          if (wb_valid) begin
            wb_valid      <= 1'b0;
            wb_wen        <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            mem_exc       <= 1'b0;
            mem_exc_cause <= MEM_EXC_NONE;
            state         <= ST_IDLE;
          end else begin
            wb_valid      <= 1'b1;
            wb_wen        <= wen_r;
            wb_rd         <= rd_r;
            wb_data       <= wb_mux;
            mem_exc       <= (cause_r != MEM_EXC_NONE);
            mem_exc_cause <= cause_r;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
